tick_counter60: RTL

TICK_COUNTER60 -- requirements
Module: tick_counter60

---
 rtl/tick_counter60_pkg.sv | 26 ++
 rtl/tick_counter60_tap_tick.sv | 34 +++
 rtl/tick_counter60.sv | 80 ++++++++
 3 files changed

// File: rtl/tick_counter60_pkg.sv
// Shared widths, default limits and load-range helper for the tick-driven BCD counter.
package tick_counter60_pkg;

   localparam int unsigned TENS_W       = 3;
   localparam int unsigned ONES_W       = 4;
   localparam int unsigned TAP_W        = 16;
   localparam int unsigned SEL_W        = 4;
   localparam int unsigned DEF_MAX_TENS = 5;
   localparam int unsigned DEF_MAX_ONES = 9;

   // True when a load value is a legal, in-range count for the given terminal value.
   function automatic logic load_valid(
      input logic [TENS_W-1:0] t,
      input logic [ONES_W-1:0] o,
      input logic [TENS_W-1:0] max_t,
      input logic [ONES_W-1:0] max_o
   );
      logic ok;
      ok = 1'b1;
      if (o > ONES_W'(9))                ok = 1'b0;
      if (t > max_t)                     ok = 1'b0;
      if ((t == max_t) && (o > max_o))   ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/tick_counter60_tap_tick.sv
// Selects one divider tap and emits a single-cycle tick on each qualified rising edge.
module tap_tick
   import tick_counter60_pkg::*;
(
   input  logic             clk,
   input  logic             RESET,
   input  logic [TAP_W-1:0] div_in,
   input  logic [SEL_W-1:0] tap_sel,
   output logic             tick
);

   logic             tap_q;
   logic [SEL_W-1:0] sel_q;
   logic             armed;
   logic             tap_bit;

   assign tap_bit = div_in[tap_sel];

   // A tap_sel change masks the edge compare for one cycle so switching taps never fakes a rise.
   always_ff @(posedge clk) begin
      if (RESET) begin
         tap_q <= 1'b0;
         sel_q <= '0;
         armed <= 1'b0;
         tick  <= 1'b0;
      end else begin
         tap_q <= tap_bit;
         sel_q <= tap_sel;
         armed <= 1'b1;
         tick  <= tap_bit & ~tap_q & (tap_sel == sel_q) & armed;
      end
   end

endmodule

// File: rtl/tick_counter60.sv
// Two-digit BCD counter advanced by qualified divider ticks, with clear, load and wrap carry.
module tick_counter60
   import tick_counter60_pkg::*;
#(
   parameter int unsigned MAX_TENS = DEF_MAX_TENS,
   parameter int unsigned MAX_ONES = DEF_MAX_ONES
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic [TAP_W-1:0]  div_in,
   input  logic [SEL_W-1:0]  tap_sel,
   input  logic              en,
   input  logic              clr,
   input  logic              load,
   input  logic [TENS_W-1:0] load_tens,
   input  logic [ONES_W-1:0] load_ones,
   output logic [TENS_W-1:0] tens,
   output logic [ONES_W-1:0] ones,
   output logic              tick,
   output logic              carry
);

   localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX_TENS);
   localparam logic [ONES_W-1:0] MAX_O = ONES_W'(MAX_ONES);

   logic [TENS_W-1:0] tens_d;
   logic [ONES_W-1:0] ones_d;
   logic              carry_d;
   logic              load_ok;

   tap_tick u_tap_tick (
      .clk     (clk),
      .RESET   (RESET),
      .div_in  (div_in),
      .tap_sel (tap_sel),
      .tick    (tick)
   );

   assign load_ok = load_valid(load_tens, load_ones, MAX_T, MAX_O);

   // Next count: clr > load > tick&en; an invalid load still blocks that cycle's increment.
   always_comb begin
      tens_d  = tens;
      ones_d  = ones;
      carry_d = 1'b0;
      if (clr) begin
         tens_d = '0;
         ones_d = '0;
      end else if (load) begin
         if (load_ok) begin
            tens_d = load_tens;
            ones_d = load_ones;
         end
      end else if (tick && en) begin
         if ((tens == MAX_T) && (ones == MAX_O)) begin
            tens_d  = '0;
            ones_d  = '0;
            carry_d = 1'b1;
         end else if (ones == ONES_W'(9)) begin
            ones_d = '0;
            tens_d = tens + TENS_W'(1);
         end else begin
            ones_d = ones + ONES_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         tens  <= '0;
         ones  <= '0;
         carry <= 1'b0;
      end else begin
         tens  <= tens_d;
         ones  <= ones_d;
         carry <= carry_d;
      end
   end

endmodule
